alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Sequencer and round-robin arbiter that shares one OP_SIZE-bit ALU (ADD, SUB, AND, OR, XOR) between two requesters.
- Owns the 4-bit CCR register (flag order C,V,N,Z, masks 1000/0100/0010/0001).
- Runs each operation through the team's standard 3-tick timing: 1 tick compute, 2 ticks CCR.
- Sits between instruction-issue logic and the shared ALU datapath.

Parameters:
- OP_SIZE, 4, operand and result width in bits (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req0_op  in  3  requester 0 opcode.
- req0_a  in  OP_SIZE  requester 0 operand A.
- req0_b  in  OP_SIZE  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- res_valid  out  1  one-cycle pulse; result fields valid.
- res_id  out  1  requester that owns the result.
- res_r  out  OP_SIZE  result R.
- res_err  out  1  illegal opcode flag for this result.
- ccr  out  4  CCR register {C,V,N,Z}.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - ccr=0000, res_valid=0, res_id=0, res_r=0, res_err=0, req0_ready=0, req1_ready=0.
  - Round-robin pointer set so requester 0 wins the first tie.
- Opcodes: 000 ADD R=A+B; 001 SUB R=A-B; 010 AND; 011 OR; 100 XOR; 101-111 illegal.
- FSM states: IDLE -> EXEC -> FLAGS -> DONE -> IDLE.
- IDLE:
  - reqX_ready is combinational: high only for the granted requester, only in IDLE.
  - If one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - A transfer is reqX_valid & reqX_ready. On transfer, latch op, A, B and id, then go to EXEC.
- EXEC: compute R at OP_SIZE+1 bits internally and store the OP_SIZE LSBs. Go to FLAGS.
- FLAGS: update ccr from the latched R.
  - N = R[OP_SIZE-1].
  - Z = (R==0).
  - ADD: C = carry out; V = operands same sign and R sign differs.
  - SUB: C = borrow (A<B unsigned); V = operand signs differ and R sign differs from A.
  - AND/OR/XOR: C and V keep their previous values.
  - Illegal opcode: R=0, ccr unchanged entirely, res_err=1.
- DONE: res_valid=1 for exactly this cycle, with res_id, res_r, res_err. Next state is IDLE.
- Latency and throughput:
  - Transfer at edge T gives res_valid high in the cycle after edge T+3.
  - ccr is stable from the FLAGS edge onward.
  - Throughput is one operation per 4 cycles.
- Result hold: res_r, res_id and res_err keep their values after the pulse until the next DONE. No backpressure on the result.
- Round-robin pointer updates only on a transfer.
- Requester drops valid with no transfer: no state change.
- Reset in EXEC, FLAGS or DONE:
  - The operation is abandoned; no res_valid.
  - All outputs take their reset values on that edge.
- Operand wrap-around is modulo 2^OP_SIZE. Overflow is reported only via C/V.

Optional Feature:
- Macro: ALU_SCHED_CTX_EN.
- When defined:
  - Two internal CCR contexts, one per requester.
  - C/V preservation and the illegal-opcode "unchanged" rule apply to the owning requester's context.
  - The ccr port shows the context of the requester served most recently.
  - Both contexts reset to 0000.
- When undefined:
  - A single shared CCR, updated by whichever requester is served.

Test Plan (OP_SIZE=4):
- Reset: rst_n=0 for 2 cycles -> ccr=0000, res_valid=0, both ready=0 while valid=0.
- req0 XOR A=1010 B=0110 -> res_valid 4th cycle after transfer, res_id=0, res_r=1100, ccr=0010.
- req0 ADD 0111+0001 -> res_r=1000, ccr=0110. Then req0 XOR 0101^0101 -> res_r=0000, ccr=0101 (V preserved).
- req1 SUB 0011-0101 -> res_r=1110, ccr=1010. Then req1 op=110 -> res_err=1, res_r=0000, ccr stays 1010.
- Both valid continuously from reset, XOR 0001^0000 each -> grant order 0,1,0,1; res_id alternates; each ready one cycle only in IDLE.
- rst_n=0 during FLAGS of an ADD 1111+0001 -> no res_valid pulse, ccr=0000. Next request completes normally.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: round-robin sequencer sharing one OP_SIZE-bit ALU between two requesters, owning the CCR {C,V,N,Z}.
// Optional ALU_SCHED_CTX_EN keeps one CCR context per requester; the ccr port shows the most recently served one.
module alu_sched #(
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_op,
  input  logic [OP_SIZE-1:0] req0_a,
  input  logic [OP_SIZE-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_op,
  input  logic [OP_SIZE-1:0] req1_a,
  input  logic [OP_SIZE-1:0] req1_b,
  output logic               res_valid,
  output logic               res_id,
  output logic [OP_SIZE-1:0] res_r,
  output logic               res_err,
  output logic [3:0]         ccr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_FLAGS = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam int MSB = OP_SIZE - 1;

  logic [1:0]         state;
  logic               last_grant;
  logic [2:0]         op_q;
  logic [OP_SIZE-1:0] a_q;
  logic [OP_SIZE-1:0] b_q;
  logic               id_q;
  logic [OP_SIZE:0]   r_q;
  logic               err_q;

  logic               grant1;
  logic               xfer;
  logic [OP_SIZE:0]   alu_r;
  logic               alu_illegal;
  logic [3:0]         cur_ccr;
  logic [3:0]         ccr_next;

  // Handshake: a transfer happens on a rising edge where reqX_valid & reqX_ready.
  // ready is combinational, only in IDLE and out of reset, for the single granted
  // requester; on a tie the requester not granted last wins.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = (state == S_IDLE) & rst_n & req0_valid & ~grant1;
    req1_ready = (state == S_IDLE) & rst_n & grant1;
    xfer       = req0_ready | req1_ready;
  end

  // Bit OP_SIZE carries the ADD carry out or the SUB borrow.
  always_comb begin
    alu_r       = '0;
    alu_illegal = 1'b0;
    case (op_q)
      OP_ADD:  alu_r = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_r = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu_r = {1'b0, a_q & b_q};
      OP_OR:   alu_r = {1'b0, a_q | b_q};
      OP_XOR:  alu_r = {1'b0, a_q ^ b_q};
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SCHED_CTX_EN
  logic [3:0] ctx0;
  logic [3:0] ctx1;
  logic       show_id;
  assign cur_ccr = id_q ? ctx1 : ctx0;
  assign ccr     = show_id ? ctx1 : ctx0;
`else
  logic [3:0] ccr_q;
  assign cur_ccr = ccr_q;
  assign ccr     = ccr_q;
`endif

  // Logic ops leave C and V as they were in the owning context.
  always_comb begin
    ccr_next    = cur_ccr;
    ccr_next[1] = r_q[MSB];
    ccr_next[0] = (r_q[MSB:0] == '0);
    if (op_q == OP_ADD) begin
      ccr_next[3] = r_q[OP_SIZE];
      ccr_next[2] = (a_q[MSB] == b_q[MSB]) & (r_q[MSB] != a_q[MSB]);
    end else if (op_q == OP_SUB) begin
      ccr_next[3] = r_q[OP_SIZE];
      ccr_next[2] = (a_q[MSB] != b_q[MSB]) & (r_q[MSB] != a_q[MSB]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      r_q        <= '0;
      err_q      <= 1'b0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_r      <= '0;
      res_err    <= 1'b0;
`ifdef ALU_SCHED_CTX_EN
      ctx0       <= '0;
      ctx1       <= '0;
      show_id    <= 1'b0;
`else
      ccr_q      <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            op_q       <= req1_ready ? req1_op : req0_op;
            a_q        <= req1_ready ? req1_a  : req0_a;
            b_q        <= req1_ready ? req1_b  : req0_b;
            id_q       <= req1_ready;
            last_grant <= req1_ready;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_q   <= alu_r;
          err_q <= alu_illegal;
          state <= S_FLAGS;
        end
        S_FLAGS: begin
`ifdef ALU_SCHED_CTX_EN
          if (!err_q) begin
            if (id_q) ctx1 <= ccr_next;
            else      ctx0 <= ccr_next;
          end
          show_id <= id_q;
`else
          if (!err_q) ccr_q <= ccr_next;
`endif
          state <= S_DONE;
        end
        default: begin
          res_valid <= 1'b1;
          res_id    <= id_q;
          res_r     <= r_q[MSB:0];
          res_err   <= err_q;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed vector table, contention and mid-operation reset sequences,
// then random single-requester traffic checked against an arithmetic flag model.
module tb_alu_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_id, res_err;
  logic [W-1:0] res_r;
  logic [3:0]   ccr;

  int checks   = 0;
  int failures = 0;

  logic [3:0] ccr_m [2];

  typedef struct {
    logic         id;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         err;
    logic [3:0]   ccr;
  } vec_t;

  vec_t tv [6];

  alu_sched #(.OP_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_id(res_id), .res_r(res_r),
    .res_err(res_err), .ccr(ccr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sgn(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - (1 << W) : int'(x);
  endfunction

  // Reference: plain integer arithmetic on the flag definitions.
  task automatic model_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] r,
                          output logic err, output logic [3:0] c_out);
    int s, sv, idx;
    logic c, v;
`ifdef ALU_SCHED_CTX_EN
    idx = int'(id);
`else
    idx = 0;
`endif
    c = ccr_m[idx][3];
    v = ccr_m[idx][2];
    err = 1'b0;
    r = '0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);  r = W'(s % (1 << W)); c = (s >= (1 << W));
        sv = sgn(a) + sgn(b);   v = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
      end
      3'd1: begin
        s = int'(a) - int'(b);  r = W'((s + (1 << W)) % (1 << W)); c = (a < b);
        sv = sgn(a) - sgn(b);   v = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: err = 1'b1;
    endcase
    if (!err) ccr_m[idx] = {c, v, r[W-1], (r == 0)};
    c_out = ccr_m[idx];
  endtask

  task automatic drop_all();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // One operation on one requester, checking handshake, latency, pulse width and hold.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r,
                        input logic exp_err, input logic [3:0] exp_ccr);
    int n;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready)) begin
      if (n >= 10) begin
        check("ready_timeout", 32'd0, 32'd1);
        drop_all();
        return;
      end
      @(negedge clk); #1;
      n++;
    end
    check("other_ready_low", id ? req0_ready : req1_ready, 32'd0);
    @(posedge clk); #1;
    drop_all();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("early_res_valid", res_valid, 32'd0);
    end
    check("ccr_at_done", ccr, exp_ccr);
    @(negedge clk);
    check("res_valid", res_valid, 32'd1);
    check("res_id", res_id, id);
    check("res_r", res_r, exp_r);
    check("res_err", res_err, exp_err);
    check("ccr", ccr, exp_ccr);
    @(negedge clk);
    check("pulse_width", res_valid, 32'd0);
    check("res_r_hold", res_r, exp_r);
    check("res_id_hold", res_id, id);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ee;
    logic [3:0]   ec;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic         rid;
    int grants, results;
    logic [3:0] gexp;

    tv[0] = '{1'b0, 3'd4, 4'b1010, 4'b0110, 4'b1100, 1'b0, 4'b0010};
    tv[1] = '{1'b0, 3'd0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 4'b0110};
    tv[2] = '{1'b0, 3'd4, 4'b0101, 4'b0101, 4'b0000, 1'b0, 4'b0101};
    tv[3] = '{1'b1, 3'd1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 4'b1010};
    tv[4] = '{1'b1, 3'd6, 4'b0110, 4'b0011, 4'b0000, 1'b1, 4'b1010};
    tv[5] = '{1'b0, 3'd0, 4'b1111, 4'b0001, 4'b0000, 1'b0, 4'b1001};

    rst_n = 1'b0;
    drop_all();
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    ccr_m[0] = '0;
    ccr_m[1] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ccr", ccr, 32'd0);
    check("rst_res_valid", res_valid, 32'd0);
    check("rst_res_r", res_r, 32'd0);
    check("rst_res_id", res_id, 32'd0);
    check("rst_res_err", res_err, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 32'd0);
    check("rst_ready1", req1_ready, 32'd0);

    // Directed vectors; the model runs alongside to stay in step for later phases
    for (int i = 0; i < 6; i++) begin
      model_op(tv[i].id, tv[i].op, tv[i].a, tv[i].b, er, ee, ec);
      run_op(tv[i].id, tv[i].op, tv[i].a, tv[i].b, tv[i].r, tv[i].err, tv[i].ccr);
    end

    // Reset during FLAGS of ADD 1111+0001
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'b1111; req0_b = 4'b0001;
    #1;
    check("flags_rst_ready", req0_ready, 32'd1);
    @(posedge clk); #1;
    drop_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("flags_rst_ccr", ccr, 32'd0);
    check("flags_rst_res_r", res_r, 32'd0);
    ccr_m[0] = '0;
    ccr_m[1] = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("flags_rst_no_valid", res_valid, 32'd0);
    end
    model_op(1'b0, 3'd0, 4'b1111, 4'b0001, er, ee, ec);
    run_op(1'b0, 3'd0, 4'b1111, 4'b0001, er, ee, ec);

    // Contention: both valid from reset, grants must alternate starting with 0
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 4'b0001; req0_b = 4'b0000;
    req1_valid = 1'b1; req1_op = 3'd4; req1_a = 4'b0001; req1_b = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ccr_m[0] = '0;
    ccr_m[1] = '0;
    gexp = 4'b1010;
    grants = 0;
    results = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 16) drop_all();
      #1;
      check("one_ready_max", req0_ready & req1_ready, 32'd0);
      if (req0_ready || req1_ready) begin
        if (grants < 4) check("grant_order", req1_ready, gexp[grants]);
        grants++;
      end
      if (res_valid) begin
        if (results < 4) begin
          model_op(gexp[results], 3'd4, 4'b0001, 4'b0000, er, ee, ec);
          check("rr_res_id", res_id, gexp[results]);
          check("rr_res_r", res_r, er);
          check("rr_ccr", ccr, ec);
        end
        results++;
      end
    end
    check("grant_count", grants, 32'd4);
    check("result_count", results, 32'd4);

    // Random single-requester traffic
    for (int i = 0; i < 40; i++) begin
      rid = 1'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom_range(0, (1 << W) - 1));
      rb  = W'($urandom_range(0, (1 << W) - 1));
      model_op(rid, rop, ra, rb, er, ee, ec);
      run_op(rid, rop, ra, rb, er, ee, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
